// File: rtl/sdram_init_responder_if.sv
// rtl/sdram_init_responder_if.sv - SDRAM command pins and init-status outputs bundle
interface sdram_init_responder_if;
  logic        DRAM_CKE;
  logic        DRAM_CS_N;
  logic        DRAM_RAS_N;
  logic        DRAM_CAS_N;
  logic        DRAM_WE_N;
  logic [1:0]  DRAM_BA;
  logic [12:0] DRAM_ADDR;
  logic        oready;
  logic        oerr;
  logic [2:0]  oerr_code;
  logic [12:0] omode;
  logic [3:0]  orefcnt;

  modport master (
    output DRAM_CKE, DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N, DRAM_BA, DRAM_ADDR,
    input  oready, oerr, oerr_code, omode, orefcnt
  );

  modport slave (
    input  DRAM_CKE, DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N, DRAM_BA, DRAM_ADDR,
    output oready, oerr, oerr_code, omode, orefcnt
  );
endinterface

// File: rtl/sdram_init_responder.sv
// rtl/sdram_init_responder.sv - SDRAM power-up/init sequence checker; SDRAM_INIT_MODE_CHECK_EN enables mode-word validation
module sdram_init_responder #(
  parameter int PWRUP_CYC = 20000,
  parameter int NREF      = 8,
  parameter int TRP       = 2,
  parameter int TRFC      = 7,
  parameter int TMRD      = 2
) (
  input logic                  iclk,
  input logic                  ireset,
  sdram_init_responder_if.slave bus
);

  localparam logic [15:0] PWRUP_W = 16'(PWRUP_CYC);
  localparam logic [4:0]  NREF_W  = 5'(NREF);
  localparam logic [7:0]  TRP_W   = 8'(TRP);
  localparam logic [7:0]  TRFC_W  = 8'(TRFC);
  localparam logic [7:0]  TMRD_W  = 8'(TMRD);

  typedef enum logic [3:0] {
    S_PWRUP, S_WAIT_PRE, S_T_RP, S_WAIT_REF, S_T_RFC,
    S_WAIT_MRS, S_T_MRD, S_READY, S_ERROR
  } state_t;

  typedef enum logic [2:0] {CMD_NOP, CMD_PRE, CMD_REF, CMD_LMR, CMD_OTHER} cmd_t;

  state_t      state_q, state_d;
  logic [15:0] pwr_cnt_q, pwr_cnt_d;
  logic [7:0]  gap_q, gap_d;
  logic [3:0]  refcnt_q, refcnt_d;
  logic [12:0] mode_q, mode_d;
  logic [2:0]  err_code_q, err_code_d;

  cmd_t       cmd;
  logic [2:0] rcw;
  logic [3:0] refcnt_inc;
  logic       e1, e2, e3, e4, e5;
  logic [2:0] err_sel;

  assign rcw        = {bus.DRAM_RAS_N, bus.DRAM_CAS_N, bus.DRAM_WE_N};
  assign refcnt_inc = (refcnt_q == 4'hF) ? refcnt_q : refcnt_q + 4'd1;

  always_comb begin
    cmd = CMD_OTHER;
    if (bus.DRAM_CS_N || rcw == 3'b111) begin
      cmd = CMD_NOP;
    end else begin
      case (rcw)
        3'b010:  cmd = CMD_PRE;
        3'b001:  cmd = CMD_REF;
        3'b000:  cmd = CMD_LMR;
        default: cmd = CMD_OTHER;
      endcase
    end
  end

`ifdef SDRAM_INIT_MODE_CHECK_EN
  logic mode_ok;
  always_comb begin
    mode_ok = (bus.DRAM_ADDR[2:0] inside {3'd0, 3'd1, 3'd2, 3'd3, 3'd7})
           && (bus.DRAM_ADDR[6:4] inside {3'd2, 3'd3})
           && (bus.DRAM_ADDR[8:7] == 2'b00);
  end
`endif

  always_comb begin
    state_d    = state_q;
    pwr_cnt_d  = pwr_cnt_q;
    gap_d      = gap_q;
    refcnt_d   = refcnt_q;
    mode_d     = mode_q;
    err_code_d = err_code_q;
    e1 = 1'b0; e2 = 1'b0; e3 = 1'b0; e4 = 1'b0; e5 = 1'b0;
    err_sel = 3'd0;

    case (state_q)
      S_PWRUP: begin
        if (cmd != CMD_NOP) begin
          e1 = 1'b1;
        end else if (!bus.DRAM_CKE) begin
          pwr_cnt_d = 16'd0;
        end else begin
          pwr_cnt_d = pwr_cnt_q + 16'd1;
          if (pwr_cnt_d == PWRUP_W) state_d = S_WAIT_PRE;
        end
      end
      S_WAIT_PRE: begin
        if (cmd == CMD_PRE && bus.DRAM_ADDR[10]) begin
          gap_d   = TRP_W;
          state_d = S_T_RP;
        end else if (cmd == CMD_PRE) begin
          e4 = 1'b1;
        end else if (cmd != CMD_NOP) begin
          e2 = 1'b1;
        end
      end
      S_WAIT_REF: begin
        if (cmd == CMD_REF) begin
          refcnt_d = refcnt_inc;
          gap_d    = TRFC_W;
          state_d  = S_T_RFC;
        end else if (cmd == CMD_PRE && bus.DRAM_ADDR[10] && refcnt_q == 4'd0) begin
          gap_d   = TRP_W;
          state_d = S_T_RP;
        end else if (cmd != CMD_NOP) begin
          e2 = 1'b1;
        end
      end
      S_WAIT_MRS: begin
        if (cmd == CMD_LMR && bus.DRAM_BA == 2'b00) begin
          mode_d  = bus.DRAM_ADDR;
          gap_d   = TMRD_W;
          state_d = S_T_MRD;
`ifdef SDRAM_INIT_MODE_CHECK_EN
          if (!mode_ok) e5 = 1'b1;
`endif
        end else if (cmd == CMD_REF) begin
          refcnt_d = refcnt_inc;
          gap_d    = TRFC_W;
          state_d  = S_T_RFC;
        end else if (cmd != CMD_NOP) begin
          e2 = 1'b1;
        end
      end
      S_T_RP, S_T_RFC, S_T_MRD: begin
        if (cmd != CMD_NOP) begin
          e3 = 1'b1;
        end else begin
          gap_d = gap_q - 8'd1;
          if (gap_d == 8'd0) begin
            if (state_q == S_T_RP)                     state_d = S_WAIT_REF;
            else if (state_q == S_T_MRD)               state_d = S_READY;
            else if ({1'b0, refcnt_q} < NREF_W)        state_d = S_WAIT_REF;
            else                                       state_d = S_WAIT_MRS;
          end
        end
      end
      S_READY: begin
        if (cmd == CMD_LMR) mode_d = bus.DRAM_ADDR;
      end
      default: ;
    endcase

    // Clock-enable must stay high for the whole checked part of the sequence.
    if (!bus.DRAM_CKE && state_q != S_PWRUP && state_q != S_READY && state_q != S_ERROR)
      e2 = 1'b1;

    if (e1)      err_sel = 3'd1;
    else if (e4) err_sel = 3'd4;
    else if (e3) err_sel = 3'd3;
    else if (e2) err_sel = 3'd2;
    else if (e5) err_sel = 3'd5;

    if (err_sel != 3'd0) begin
      state_d    = S_ERROR;
      err_code_d = err_sel;
      pwr_cnt_d  = pwr_cnt_q;
      gap_d      = gap_q;
      refcnt_d   = refcnt_q;
      if (err_sel != 3'd5) mode_d = mode_q;
    end
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state_q    <= S_PWRUP;
      pwr_cnt_q  <= 16'd0;
      gap_q      <= 8'd0;
      refcnt_q   <= 4'd0;
      mode_q     <= 13'd0;
      err_code_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      pwr_cnt_q  <= pwr_cnt_d;
      gap_q      <= gap_d;
      refcnt_q   <= refcnt_d;
      mode_q     <= mode_d;
      err_code_q <= err_code_d;
    end
  end

  assign bus.oready    = (state_q == S_READY);
  assign bus.oerr      = (state_q == S_ERROR);
  assign bus.oerr_code = err_code_q;
  assign bus.omode     = mode_q;
  assign bus.orefcnt   = refcnt_q;

endmodule

// File: tb/tb_sdram_init_responder.sv
// tb/tb_sdram_init_responder.sv - directed vector bench for sdram_init_responder
module tb_sdram_init_responder;

  localparam logic [2:0] C_NOP = 3'b111;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [2:0] C_LMR = 3'b000;
  localparam logic [2:0] C_RD  = 3'b101;

  typedef struct {
    logic        cke;
    logic        cs_n;
    logic [2:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic        chk;
    logic        rdy;
    logic        err;
    logic [2:0]  code;
    logic [12:0] mode;
    logic [3:0]  refc;
  } vec_t;

  logic iclk = 1'b0;
  logic ireset;
  int   tests = 0;
  int   fails = 0;
  vec_t vecs[$];

  sdram_init_responder_if bus();

  sdram_init_responder #(
    .PWRUP_CYC(10), .NREF(2), .TRP(2), .TRFC(7), .TMRD(2)
  ) dut (
    .iclk  (iclk),
    .ireset(ireset),
    .bus   (bus)
  );

  always #5 iclk = ~iclk;

  function automatic vec_t mk(logic cke, logic cs_n, logic [2:0] cmd, logic [1:0] ba,
                              logic [12:0] addr, logic chk, logic rdy, logic err,
                              logic [2:0] code, logic [12:0] mode, logic [3:0] refc);
    vec_t v;
    v.cke = cke; v.cs_n = cs_n; v.cmd = cmd; v.ba = ba; v.addr = addr;
    v.chk = chk; v.rdy = rdy; v.err = err; v.code = code; v.mode = mode; v.refc = refc;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic rdy, input logic err,
                         input logic [2:0] code, input logic [12:0] mode, input logic [3:0] refc);
    chk({tag, ".oready"},    int'(bus.oready),    int'(rdy));
    chk({tag, ".oerr"},      int'(bus.oerr),      int'(err));
    chk({tag, ".oerr_code"}, int'(bus.oerr_code), int'(code));
    chk({tag, ".omode"},     int'(bus.omode),     int'(mode));
    chk({tag, ".orefcnt"},   int'(bus.orefcnt),   int'(refc));
  endtask

  task automatic cyc(input logic cke, input logic cs_n, input logic [2:0] cmd,
                     input logic [1:0] ba, input logic [12:0] addr);
    bus.DRAM_CKE   = cke;
    bus.DRAM_CS_N  = cs_n;
    {bus.DRAM_RAS_N, bus.DRAM_CAS_N, bus.DRAM_WE_N} = cmd;
    bus.DRAM_BA    = ba;
    bus.DRAM_ADDR  = addr;
    @(posedge iclk);
    @(negedge iclk);
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, C_NOP, 2'b00, 13'h0);
  endtask

  task automatic do_reset();
    ireset = 1'b1;
    bus.DRAM_CKE = 1'b1; bus.DRAM_CS_N = 1'b1;
    {bus.DRAM_RAS_N, bus.DRAM_CAS_N, bus.DRAM_WE_N} = C_NOP;
    bus.DRAM_BA = 2'b00; bus.DRAM_ADDR = 13'h0;
    repeat (2) @(negedge iclk);
    ireset = 1'b0;
  endtask

  task automatic to_wait_ref();
    nops(10);
    cyc(1'b1, 1'b0, C_PRE, 2'b00, 13'h0400);
    nops(2);
  endtask

  task automatic legal_full(input logic [12:0] mode);
    to_wait_ref();
    for (int r = 0; r < 2; r++) begin
      cyc(1'b1, 1'b0, C_REF, 2'b00, 13'h0);
      nops(7);
    end
    cyc(1'b1, 1'b0, C_LMR, 2'b00, mode);
    nops(2);
  endtask

  initial begin
    // Golden init sequence followed by unchecked traffic in READY.
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 0, C_NOP, 0, 13'h0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, C_LMR, 0, 13'h0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(1, 0, C_NOP, 0, 13'h0, i == 4, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, C_PRE, 0, 13'h0400, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, C_NOP, 0, 13'h0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, C_NOP, 0, 13'h0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, C_REF, 0, 13'h0, 1, 0, 0, 0, 0, 1));
    for (int i = 0; i < 7; i++) vecs.push_back(mk(1, 0, C_NOP, 0, 13'h0, i == 6, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, C_REF, 0, 13'h0, 1, 0, 0, 0, 0, 2));
    for (int i = 0; i < 7; i++) vecs.push_back(mk(1, 0, C_NOP, 0, 13'h0, i == 6, 0, 0, 0, 0, 2));
    vecs.push_back(mk(1, 0, C_LMR, 0, 13'h0023, 1, 0, 0, 0, 13'h0023, 2));
    vecs.push_back(mk(1, 0, C_NOP, 0, 13'h0, 1, 0, 0, 0, 13'h0023, 2));
    vecs.push_back(mk(1, 0, C_NOP, 0, 13'h0, 1, 1, 0, 0, 13'h0023, 2));
    vecs.push_back(mk(1, 0, C_LMR, 1, 13'h0031, 1, 1, 0, 0, 13'h0031, 2));
    vecs.push_back(mk(0, 0, C_RD,  0, 13'h0, 1, 1, 0, 0, 13'h0031, 2));

    do_reset();
    ireset = 1'b1;
    @(negedge iclk);
    chk_all("reset", 0, 0, 0, 13'h0, 4'h0);
    ireset = 1'b0;

    foreach (vecs[i]) begin
      cyc(vecs[i].cke, vecs[i].cs_n, vecs[i].cmd, vecs[i].ba, vecs[i].addr);
      if (vecs[i].chk)
        chk_all($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].err, vecs[i].code,
                vecs[i].mode, vecs[i].refc);
    end

    // Early PRECHARGE; later violations must not overwrite the first code.
    do_reset();
    nops(5);
    cyc(1'b1, 1'b0, C_PRE, 2'b00, 13'h0400);
    chk_all("early_pre", 0, 1, 3'd1, 13'h0, 4'h0);
    cyc(1'b1, 1'b0, C_REF, 2'b00, 13'h0);
    nops(12);
    chk_all("sticky", 0, 1, 3'd1, 13'h0, 4'h0);

    // CKE low in PWRUP restarts the count: 9 NOPs are then one short.
    do_reset();
    nops(9);
    cyc(1'b0, 1'b0, C_NOP, 2'b00, 13'h0);
    nops(9);
    cyc(1'b1, 1'b0, C_PRE, 2'b00, 13'h0400);
    chk("cke_clear.code", int'(bus.oerr_code), 1);

    // Reset mid-PWRUP discards progress.
    do_reset();
    nops(6);
    do_reset();
    nops(9);
    cyc(1'b1, 1'b0, C_PRE, 2'b00, 13'h0400);
    chk("rst_mid.code", int'(bus.oerr_code), 1);

    // REFRESH three cycles after the previous one violates tRFC.
    do_reset();
    to_wait_ref();
    cyc(1'b1, 1'b0, C_REF, 2'b00, 13'h0);
    nops(2);
    cyc(1'b1, 1'b0, C_REF, 2'b00, 13'h0);
    chk_all("trfc", 0, 1, 3'd3, 13'h0, 4'h1);

    // Extra PRECHARGE-all before first refresh is legal; CKE low afterwards is not.
    do_reset();
    to_wait_ref();
    cyc(1'b1, 1'b0, C_PRE, 2'b00, 13'h0400);
    nops(2);
    chk("extra_pre.err", int'(bus.oerr), 0);
    cyc(1'b0, 1'b0, C_NOP, 2'b00, 13'h0);
    chk("cke_low.code", int'(bus.oerr_code), 2);

    // Code 4 outranks code 2 when both happen on one cycle.
    do_reset();
    nops(10);
    cyc(1'b0, 1'b0, C_PRE, 2'b00, 13'h0000);
    chk("prio42.code", int'(bus.oerr_code), 4);

    // PRECHARGE without A10, then reset out of ERROR and complete the sequence.
    do_reset();
    nops(10);
    cyc(1'b1, 1'b0, C_PRE, 2'b00, 13'h0000);
    chk_all("a10_low", 0, 1, 3'd4, 13'h0, 4'h0);
    do_reset();
    chk_all("after_rst", 0, 0, 3'd0, 13'h0, 4'h0);
    legal_full(13'h0023);
    chk_all("recover", 1, 0, 3'd0, 13'h0023, 4'h2);

    // CAS latency 4 mode word.
    do_reset();
    legal_full(13'h0043);
`ifdef SDRAM_INIT_MODE_CHECK_EN
    chk_all("cl4", 0, 1, 3'd5, 13'h0043, 4'h2);
`else
    chk_all("cl4", 1, 0, 3'd0, 13'h0043, 4'h2);
`endif

    // Asynchronous reset takes effect between clock edges.
    #2 ireset = 1'b1;
    #1 chk_all("async_rst", 0, 0, 3'd0, 13'h0, 4'h0);
    @(negedge iclk);
    ireset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sdram_init_responder.md
SDRAM_INIT_RESPONDER -- requirements
Module: sdram_init_responder

Interface
REQ-001 Parameter PWRUP_CYC, default 20000: minimum number of CKE-high NOP/deselect cycles before the first command.
REQ-002 Parameter NREF, default 8: number of AUTO REFRESH commands required before LOAD MODE.
REQ-003 Parameters TRP, TRFC, TMRD, defaults 2, 7, 2: minimum cycle gaps after PRECHARGE, AUTO REFRESH and LOAD MODE respectively.
REQ-004 iclk  in  1  single clock; all pins sampled on rising edge.
REQ-005 ireset  in  1  asynchronous, active-high reset.
REQ-006 DRAM_CKE, DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N  in  1 each  SDRAM command pins from the initializer.
REQ-007 DRAM_BA  in  2  bank select; DRAM_ADDR  in  13  address / mode word.
REQ-008 oready  out  1  init sequence accepted; device ready for normal commands.
REQ-009 oerr  out  1  sticky protocol violation flag; oerr_code  out  3  first violation cause.
REQ-010 omode  out  13  captured mode register; orefcnt  out  4  AUTO REFRESH commands counted.

Function
REQ-011 Decode: CS_N=1 or RAS/CAS/WE=111 -> NOP; 010 PRECHARGE; 001 AUTO REFRESH; 000 LOAD MODE; any other code -> OTHER.
REQ-012 States: PWRUP, WAIT_PRE, T_RP, WAIT_REF, T_RFC, WAIT_MRS, T_MRD, READY, ERROR.
REQ-013 PWRUP: 16-bit counter increments on each NOP cycle with CKE=1; CKE=0 clears it; at count PWRUP_CYC -> WAIT_PRE.
REQ-014 Any non-NOP in PWRUP -> ERROR, code 1 (early command).
REQ-015 WAIT_PRE: PRECHARGE with ADDR[10]=1 -> T_RP; PRECHARGE with ADDR[10]=0 -> ERROR code 4; any other non-NOP -> ERROR code 2.
REQ-016 T_RP/T_RFC/T_MRD: gap counter loads at command cycle; any non-NOP before TRP/TRFC/TMRD cycles have elapsed -> ERROR code 3; on expiry -> next wait state.
REQ-017 WAIT_REF: AUTO REFRESH increments orefcnt (saturating at 15) -> T_RFC; after T_RFC, return to WAIT_REF while orefcnt < NREF, else WAIT_MRS.
REQ-018 Extra PRECHARGE-all in WAIT_REF before the first refresh is legal (-> T_RP); any other non-NOP in WAIT_REF -> ERROR code 2.
REQ-019 WAIT_MRS: LOAD MODE with BA=00 captures ADDR into omode same edge -> T_MRD; AUTO REFRESH additional is legal (-> T_RFC); other non-NOP -> ERROR code 2.
REQ-020 T_MRD expiry -> READY; oready asserts on the edge entering READY and holds.
REQ-021 READY: all commands accepted without checking; LOAD MODE still updates omode.
REQ-022 ERROR is terminal until reset; oerr=1, oready=0; oerr_code holds first cause, later violations ignored.
REQ-023 Simultaneous error conditions on one cycle: priority code 1 > 4 > 3 > 2 > 5.
REQ-024 CKE=0 in any state after PWRUP other than READY -> ERROR code 2.

Reset
REQ-025 ireset=1 asynchronously forces state PWRUP, all counters 0, oready=0, oerr=0, oerr_code=0, omode=0, orefcnt=0.
REQ-026 Reset asserted mid-sequence (any state, including READY/ERROR) discards all progress; sequence must restart with full PWRUP_CYC.

Configuration
REQ-027 Macro SDRAM_INIT_MODE_CHECK_EN defined: LOAD MODE in WAIT_MRS validates ADDR[2:0] in {000,001,010,011,111}, ADDR[6:4] in {010,011}, ADDR[8:7]=00; failure -> ERROR code 5, omode still captured.
REQ-028 Macro undefined: any LOAD MODE word accepted; code 5 never produced.

Verification (bench uses PWRUP_CYC=10, NREF=2, TRP=2, TRFC=7, TMRD=2)
REQ-029 Reset, 10 NOPs CKE=1, PRECHARGE A10=1, 2 NOPs, 2x(REFRESH + 7 NOPs), LOAD MODE ADDR=0x0023, 2 NOPs -> oready=1, omode=0x0023, orefcnt=2, oerr=0.
REQ-030 PRECHARGE issued after 5 NOPs -> oerr=1, oerr_code=1, oready stays 0.
REQ-031 Legal start, REFRESH issued 3 cycles after first REFRESH -> oerr=1, oerr_code=3.
REQ-032 PRECHARGE with A10=0 at WAIT_PRE -> oerr_code=4; ireset pulse mid-ERROR -> all outputs 0, full legal sequence then sets oready=1.
REQ-033 With SDRAM_INIT_MODE_CHECK_EN, LOAD MODE ADDR=0x0043 (CL=4) -> oerr_code=5, omode=0x0043; without macro -> oready=1.
